// File: rtl/seq_pkg.sv
// Shared types and widths for the serial pattern transmitter.
package seq_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int REP_W     = 4;
   localparam int GAP_W     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width of the bit index / length field for a given pattern width.
   function automatic int idx_w(input int pat_w);
      return $clog2(pat_w);
   endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a captured MSB-first pattern with idle gaps.
// One-cycle start latency; every output is registered.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [PAT_W-1:0]        pat,
   input  logic [idx_w(PAT_W)-1:0] len,
   input  logic [REP_W-1:0]        reps,
   input  logic [GAP_W-1:0]        gap,
   output logic                    xout,
   output logic                    xvalid,
   output logic                    sof,
   output logic                    busy,
   output logic                    done
);

   localparam int LEN_W = idx_w(PAT_W);

   state_t           state;
   logic [LEN_W-1:0] idx;
   logic [REP_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic [GAP_W-1:0] gap_q;

   // idx is the index of the bit currently on xout; rep_cnt counts repetitions
   // still to start after the current one; gap_cnt counts gap cycles still to come.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         rep_cnt <= '0;
         gap_cnt <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         xout    <= 1'b0;
         xvalid  <= 1'b0;
         sof     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         sof  <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               xout   <= 1'b0;
               xvalid <= 1'b0;
               busy   <= 1'b0;
               if (start) begin
                  pat_q <= pat;
                  len_q <= len;
                  gap_q <= gap;
                  if (reps != '0) begin
                     state   <= SHIFT;
                     idx     <= len;
                     rep_cnt <= reps - REP_W'(1);
                     xout    <= pat[len];
                     xvalid  <= 1'b1;
                     sof     <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     state   <= DONE;
                     rep_cnt <= '0;
                     done    <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (idx != '0) begin
                  idx  <= idx - LEN_W'(1);
                  xout <= pat_q[idx - LEN_W'(1)];
               end else if (rep_cnt == '0) begin
                  state  <= DONE;
                  xout   <= 1'b0;
                  xvalid <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else if (gap_q != '0) begin
                  state   <= GAP;
                  gap_cnt <= gap_q - GAP_W'(1);
                  xout    <= 1'b0;
                  xvalid  <= 1'b0;
               end else begin
                  idx     <= len_q;
                  rep_cnt <= rep_cnt - REP_W'(1);
                  xout    <= pat_q[len_q];
                  sof     <= 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state   <= SHIFT;
                  idx     <= len_q;
                  rep_cnt <= rep_cnt - REP_W'(1);
                  xout    <= pat_q[len_q];
                  xvalid  <= 1'b1;
                  sof     <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            DONE: begin
               state  <= IDLE;
               xout   <= 1'b0;
               xvalid <= 1'b0;
               busy   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; observed word is {xout,xvalid,sof,busy,done}.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] pat;
   logic [2:0] len;
   logic [3:0] reps, gap;
   logic       xout, xvalid, sof, busy, done;

   int errors = 0;
   int checks = 0;
   logic [4:0] exp_q[$];

   localparam logic [4:0] B1F = 5'b11110;
   localparam logic [4:0] B0F = 5'b01110;
   localparam logic [4:0] B1  = 5'b11010;
   localparam logic [4:0] B0  = 5'b01010;
   localparam logic [4:0] GP  = 5'b00010;
   localparam logic [4:0] DN  = 5'b00001;
   localparam logic [4:0] ID  = 5'b00000;

   seq_pattern_tx #(.PAT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len),
      .reps(reps), .gap(gap), .xout(xout), .xvalid(xvalid), .sof(sof),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {xout, xvalid, sof, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Start is held for the first edge only; each later cycle is compared in order.
   task automatic run_seq(input string tag);
      int n = 0;
      while (exp_q.size() > 0) begin
         tick();
         start = 1'b0;
         chk($sformatf("%s[%0d]", tag, n), 32'(outs()), 32'(exp_q.pop_front()));
         n++;
      end
   endtask

   task automatic setup(input logic [7:0] p, input logic [2:0] l,
                        input logic [3:0] r, input logic [3:0] g);
      pat = p; len = l; reps = r; gap = g; start = 1'b1;
   endtask

   initial begin
      int done_at, nbits, nsof, bad;
      rst = 1'b1; start = 1'b0; pat = '0; len = '0; reps = '0; gap = '0;
      tick();
      tick();
      chk("reset_outs", 32'(outs()), 32'(ID));

      // Start in the very first cycle after reset release.
      rst = 1'b0;
      setup(8'h0B, 3'd3, 4'd1, 4'd0);
      exp_q = {B1F, B0, B1, B1, DN, ID};
      run_seq("single");

      // Back-to-back start in the IDLE cycle after DONE.
      setup(8'h0B, 3'd3, 4'd2, 4'd0);
      exp_q = {B1F, B0, B1, B1, B1F, B0, B1, B1, DN, ID};
      run_seq("b2b");

      setup(8'hA5, 3'd7, 4'd2, 4'd3);
      exp_q = {B1F, B0, B1, B0, B0, B1, B0, B1, GP, GP, GP,
               B1F, B0, B1, B0, B0, B1, B0, B1, DN, ID};
      run_seq("gap3");

      // reps=0, with start held through the DONE cycle.
      setup(8'hFF, 3'd7, 4'd0, 4'd0);
      tick();
      chk("reps0_done", 32'(outs()), 32'(DN));
      tick();
      chk("done_ignores_start", 32'(outs()), 32'(ID));
      start = 1'b0;
      tick();
      chk("reps0_idle", 32'(outs()), 32'(ID));

      // Input changes and start while busy.
      setup(8'h0B, 3'd3, 4'd1, 4'd0);
      tick();
      chk("mid_b0", 32'(outs()), 32'(B1F));
      setup(8'h00, 3'd7, 4'd15, 4'd15);
      tick();
      chk("mid_b1", 32'(outs()), 32'(B0));
      tick();
      chk("mid_b2", 32'(outs()), 32'(B1));
      tick();
      chk("mid_b3", 32'(outs()), 32'(B1));
      start = 1'b0;
      tick();
      chk("mid_done", 32'(outs()), 32'(DN));
      tick();
      chk("mid_idle", 32'(outs()), 32'(ID));

      // Reset during SHIFT aborts without done, then immediate restart.
      setup(8'hA5, 3'd7, 4'd3, 4'd2);
      tick();
      start = 1'b0;
      chk("abort_b0", 32'(outs()), 32'(B1F));
      tick();
      chk("abort_b1", 32'(outs()), 32'(B0));
      rst = 1'b1;
      tick();
      chk("abort_rst0", 32'(outs()), 32'(ID));
      tick();
      chk("abort_rst1", 32'(outs()), 32'(ID));
      rst = 1'b0;
      setup(8'h0B, 3'd3, 4'd1, 4'd0);
      exp_q = {B1F, B0, B1, B1, DN, ID};
      run_seq("restart");

      // 1-bit pattern of 0 checks the len=0 edge and sof with a zero bit.
      setup(8'hFE, 3'd0, 4'd2, 4'd1);
      exp_q = {B0F, GP, B0F, DN, ID};
      run_seq("len0");

      // Maximum settings: 15*8 bits + 14*15 gap cycles, DONE on cycle 331.
      setup(8'hFF, 3'd7, 4'd15, 4'd15);
      done_at = 0; nbits = 0; nsof = 0; bad = 0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         tick();
         start = 1'b0;
         if (xvalid) nbits++;
         if (sof) nsof++;
         if (!xvalid && xout) bad++;
         if (xvalid && !xout) bad++;
         if (done) begin
            done_at = cyc;
            break;
         end
      end
      chk("max_done_cycle", 32'(done_at), 32'd331);
      chk("max_bits", 32'(nbits), 32'd120);
      chk("max_sof", 32'(nsof), 32'd15);
      chk("max_xout_rule", 32'(bad), 32'd0);
      tick();
      chk("max_idle", 32'(outs()), 32'(ID));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
